param_fifo: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's 8-bit push/pop FIFO.
- Adds configurable width and depth, selectable read mode (registered or first-word-fall-through), occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
- Sits between producer and consumer stages in the core datapath, in a single clock domain.

---
 rtl/param_fifo.sv | 122 ++++++++++++
 tb/tb_param_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock FIFO with registered or
// first-word-fall-through read, occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in            write data (WIDTH)
//   push          write request
//   pop           read request
//   out           read data (WIDTH)
//   out_valid     FWFT=0: one-cycle pulse with a popped word; FWFT=1: !empty
//   empty, full   count==0, count==DEPTH
//   almost_empty  count <= AE_LEVEL
//   almost_full   count >= AF_LEVEL
//   count         current occupancy ($clog2(DEPTH+1))
//   overflow      sticky: a push was rejected
//   underflow     sticky: a pop was rejected
//   clr_err       synchronous clear of overflow/underflow (a new error wins)
module param_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           out,
  output logic                       out_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_nxt;

  // A pop frees a slot in the same edge, so a full FIFO still takes a push
  // when it is also being popped.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + 1'b1;
    else if (pop_ok && !push_ok)
      count_nxt = count - 1'b1;
  end

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= (AF_LEVEL == 0);
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)
        rd_ptr <= ptr_inc(rd_ptr);
      count        <= count_nxt;
      // Flags follow the post-update count so they agree with count.
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CW'(DEPTH));
      almost_empty <= (32'(count_nxt) <= AE_LEVEL);
      almost_full  <= (32'(count_nxt) >= AF_LEVEL);
      overflow     <= (push & ~push_ok) | (overflow & ~clr_err);
      underflow    <= (pop & ~pop_ok) | (underflow & ~clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so the
    // unreset memory never shows through.
    assign out       = empty ? '0 : mem[rd_ptr];
    assign out_valid = ~empty;
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out       <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= pop_ok;
        if (pop_ok)
          out <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: DEPTH=4 registered read, DEPTH=5 registered
// read for pointer wrap, DEPTH=4 first-word-fall-through.
module tb_param_fifo;

  logic clk;
  logic rst_n;

  // a: DEPTH=4, FWFT=0
  logic [7:0] a_in, a_out;
  logic       a_push, a_pop, a_clr, a_ov, a_em, a_fu, a_ae, a_af, a_ovf, a_udf;
  logic [2:0] a_cnt;
  // b: DEPTH=5, FWFT=0
  logic [7:0] b_in, b_out;
  logic       b_push, b_pop, b_clr, b_ov, b_em, b_fu, b_ae, b_af, b_ovf, b_udf;
  logic [2:0] b_cnt;
  // c: DEPTH=4, FWFT=1
  logic [7:0] c_in, c_out;
  logic       c_push, c_pop, c_clr, c_ov, c_em, c_fu, c_ae, c_af, c_ovf, c_udf;
  logic [2:0] c_cnt;

  int total = 0;
  int bad   = 0;

  param_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .push(a_push), .pop(a_pop),
    .out(a_out), .out_valid(a_ov), .empty(a_em), .full(a_fu),
    .almost_empty(a_ae), .almost_full(a_af), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_udf), .clr_err(a_clr));

  param_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .push(b_push), .pop(b_pop),
    .out(b_out), .out_valid(b_ov), .empty(b_em), .full(b_fu),
    .almost_empty(b_ae), .almost_full(b_af), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_udf), .clr_err(b_clr));

  param_fifo #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in(c_in), .push(c_push), .pop(c_pop),
    .out(c_out), .out_valid(c_ov), .empty(c_em), .full(c_fu),
    .almost_empty(c_ae), .almost_full(c_af), .count(c_cnt),
    .overflow(c_ovf), .underflow(c_udf), .clr_err(c_clr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus table for the DEPTH=5 wrap test: {push, pop, data}
  typedef struct { logic push; logic pop; logic [7:0] d; } op_t;
  op_t ops[$];
  logic [7:0] gold[$];

  initial begin
    rst_n = 1'b0;
    {a_in, a_push, a_pop, a_clr} = '0;
    {b_in, b_push, b_pop, b_clr} = '0;
    {c_in, c_push, c_pop, c_clr} = '0;
    #12;
    chk("rst_count", 32'(a_cnt), 0);
    chk("rst_empty", 32'(a_em), 1);
    chk("rst_full", 32'(a_fu), 0);
    chk("rst_ae", 32'(a_ae), 1);
    chk("rst_af", 32'(a_af), 0);
    chk("rst_ov", 32'(a_ov), 0);
    chk("rst_out", 32'(a_out), 0);
    chk("rst_c_ov", 32'(c_ov), 0);
    rst_n = 1'b1;
    tick();

    // Fill 1..4
    for (int i = 1; i <= 4; i++) begin
      a_push = 1'b1; a_in = 8'(i);
      tick();
      chk($sformatf("fill_count%0d", i), 32'(a_cnt), 32'(i));
      chk($sformatf("fill_af%0d", i), 32'(a_af), (i >= 3) ? 1 : 0);
      chk($sformatf("fill_full%0d", i), 32'(a_fu), (i == 4) ? 1 : 0);
      chk($sformatf("fill_ae%0d", i), 32'(a_ae), (i <= 1) ? 1 : 0);
    end

    // Overflow, clear, set-wins
    a_in = 8'd5;
    tick();
    chk("ovf_set", 32'(a_ovf), 1);
    chk("ovf_count", 32'(a_cnt), 4);
    a_push = 1'b0; a_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(a_ovf), 0);
    a_push = 1'b1; a_in = 8'd6;
    tick();
    chk("ovf_set_wins", 32'(a_ovf), 1);
    a_push = 1'b0;
    tick();
    chk("ovf_clr2", 32'(a_ovf), 0);
    a_clr = 1'b0;

    // Drain: 1..4, no 5 or 6
    a_pop = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("drain_out%0d", i), 32'(a_out), 32'(i));
      chk($sformatf("drain_ov%0d", i), 32'(a_ov), 1);
    end
    chk("drain_empty", 32'(a_em), 1);
    a_pop = 1'b0;
    tick();
    chk("idle_ov", 32'(a_ov), 0);
    chk("idle_out_hold", 32'(a_out), 4);

    // Pop while empty
    a_pop = 1'b1;
    tick();
    chk("udf_set", 32'(a_udf), 1);
    chk("udf_ov", 32'(a_ov), 0);
    chk("udf_out_hold", 32'(a_out), 4);
    chk("udf_count", 32'(a_cnt), 0);
    a_pop = 1'b0; a_clr = 1'b1;
    tick();
    chk("udf_clr", 32'(a_udf), 0);
    a_clr = 1'b0;

    // Push+pop on full
    for (int i = 1; i <= 4; i++) begin
      a_push = 1'b1; a_in = 8'(i);
      tick();
    end
    a_in = 8'd9; a_pop = 1'b1;
    tick();
    chk("pp_full_count", 32'(a_cnt), 4);
    chk("pp_full_out", 32'(a_out), 1);
    chk("pp_full_ovf", 32'(a_ovf), 0);
    a_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = (i == 3) ? 8'd9 : 8'(i + 2);
      tick();
      chk($sformatf("pp_drain%0d", i), 32'(a_out), 32'(e));
    end

    // Push+pop on empty
    a_push = 1'b1; a_in = 8'd7; a_pop = 1'b1;
    tick();
    chk("pe_udf", 32'(a_udf), 1);
    chk("pe_count", 32'(a_cnt), 1);
    chk("pe_ov", 32'(a_ov), 0);
    a_push = 1'b0;
    tick();
    chk("pe_out", 32'(a_out), 7);
    chk("pe_ov2", 32'(a_ov), 1);
    chk("pe_count2", 32'(a_cnt), 0);
    a_pop = 1'b0; a_clr = 1'b1;
    tick();
    a_clr = 1'b0;

    // DEPTH=5 wrap against a golden queue
    ops = '{'{1,0,8'd5}, '{1,0,8'd6}, '{0,1,8'd0}, '{0,1,8'd0},
            '{1,0,8'd7}, '{1,0,8'd8}, '{1,0,8'd9}, '{1,0,8'd10},
            '{1,0,8'd11}, '{1,0,8'd99}, '{0,1,8'd0}, '{1,1,8'd12},
            '{0,1,8'd0}, '{1,1,8'd13}, '{0,1,8'd0}, '{0,1,8'd0},
            '{0,1,8'd0}, '{0,1,8'd0}, '{0,0,8'd0}};
    foreach (ops[k]) begin
      logic pok, wok;
      logic [7:0] e;
      e = 8'd0;
      b_push = ops[k].push; b_pop = ops[k].pop; b_in = ops[k].d;
      pok = ops[k].pop && (gold.size() > 0);
      wok = ops[k].push && ((gold.size() < 5) || pok);
      tick();
      if (pok) e = gold.pop_front();
      if (wok) gold.push_back(ops[k].d);
      chk($sformatf("wrap_ov%0d", k), 32'(b_ov), 32'(pok));
      if (pok) chk($sformatf("wrap_out%0d", k), 32'(b_out), 32'(e));
      chk($sformatf("wrap_count%0d", k), 32'(b_cnt), 32'(gold.size()));
      chk($sformatf("wrap_full%0d", k), 32'(b_fu), (gold.size() == 5) ? 1 : 0);
    end
    chk("wrap_ovf", 32'(b_ovf), 1);
    b_push = 1'b0; b_pop = 1'b0;

    // FWFT
    c_push = 1'b1; c_in = 8'hA5;
    tick();
    chk("fwft_out", 32'(c_out), 32'h A5);
    chk("fwft_ov", 32'(c_ov), 1);
    chk("fwft_empty", 32'(c_em), 0);
    c_in = 8'h3C;
    tick();
    chk("fwft_head_hold", 32'(c_out), 32'h A5);
    c_push = 1'b0; c_pop = 1'b1;
    tick();
    chk("fwft_next", 32'(c_out), 32'h 3C);
    chk("fwft_count", 32'(c_cnt), 1);
    tick();
    chk("fwft_empty2", 32'(c_em), 1);
    chk("fwft_ov2", 32'(c_ov), 0);
    c_pop = 1'b0;

    // Async reset mid-stream
    a_push = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in = 8'(i + 20);
      tick();
    end
    a_push = 1'b0;
    chk("prerst_count", 32'(a_cnt), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(a_cnt), 0);
    chk("arst_empty", 32'(a_em), 1);
    chk("arst_ae", 32'(a_ae), 1);
    chk("arst_af", 32'(a_af), 0);
    chk("arst_out", 32'(a_out), 0);
    chk("arst_ov", 32'(a_ov), 0);
    chk("arst_b_ovf", 32'(b_ovf), 0);
    #2;
    rst_n = 1'b1;
    a_pop = 1'b1;
    tick();
    chk("post_udf", 32'(a_udf), 1);
    chk("post_ov", 32'(a_ov), 0);
    chk("post_out", 32'(a_out), 0);
    chk("post_count", 32'(a_cnt), 0);
    a_pop = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
